// File: rtl/eprisc_uart_defs.sv
// Shared UART register map, control bit positions and drain FSM encoding
// for the epRISC UART transmit queue.
package eprisc_uart_defs;

    localparam logic [1:0] UART_CTRL = 2'd0;
    localparam logic [1:0] UART_DATA = 2'd1;
    localparam logic [1:0] UART_RXD  = 2'd2;
    localparam logic [1:0] UART_ID   = 2'd3;

    localparam int CTRL_SEND      = 7;
    localparam int CTRL_INTRECV   = 6;
    localparam int CTRL_ALLOWRECV = 5;

    localparam int STAT_EMPTY    = 8;
    localparam int STAT_FULL     = 9;
    localparam int STAT_OVERFLOW = 10;
    localparam int STAT_BUSY     = 11;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RXRD  = 3'd1,
        ST_POLL  = 3'd2,
        ST_WDATA = 3'd3,
        ST_WCTRL = 3'd4,
        ST_GAP   = 3'd5
    } txq_state_t;

endpackage

// File: rtl/eprisc_sync_fifo.sv
// Byte-wide synchronous FIFO with flush; full pushes and empty pops are ignored,
// and flush overrides any push/pop in the same cycle.
module eprisc_sync_fifo #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          iClk,
    input  logic          iRst,
    input  logic          iPush,
    input  logic [7:0]    iData,
    input  logic          iPop,
    input  logic          iFlush,
    output logic [7:0]    oData,
    output logic          oFull,
    output logic          oEmpty,
    output logic [AW:0]   oCount
);

    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          w_push;
    logic          w_pop;

    assign oFull  = (r_count == (AW+1)'(DEPTH));
    assign oEmpty = (r_count == '0);
    assign oCount = r_count;
    assign oData  = r_mem[r_rd_ptr];

    assign w_push = iPush && !oFull  && !iFlush;
    assign w_pop  = iPop  && !oEmpty && !iFlush;

    always_ff @(posedge iClk) begin
        if (w_push) r_mem[r_wr_ptr] <= iData;
    end

    // Pointers are AW bits wide, so they wrap modulo DEPTH for free.
    always_ff @(posedge iClk or negedge iRst) begin
        if (!iRst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (iFlush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/eprisc_uart_txq.sv
// UART transmit queue and bus master: buffers CPU bytes, drains them into the
// UART by polling its busy bit, and mirrors the UART receive register while idle.
module eprisc_uart_txq
    import eprisc_uart_defs::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic        iClk,
    input  logic        iRst,
    input  logic [1:0]  iAddr,
    input  logic [15:0] iData,
    output logic [15:0] oData,
    input  logic        iWrite,
    input  logic        iEnable,
    output logic        oInt,
    output logic [1:0]  oUAddr,
    output logic [15:0] oUData,
    input  logic [15:0] iUData,
    output logic        oUWrite,
    output logic        oUEnable
);

    txq_state_t  r_state;
    txq_state_t  w_next;
    logic [6:0]  r_cfg;
    logic        r_irq_en;
    logic        r_overflow;
    logic [15:0] r_rx_mirror;
    logic [7:0]  r_tx_byte;

    logic        w_cfg_wr;
    logic        w_flush;
    logic        w_cpu_push;
    logic        w_stat_rd;
    logic        w_pop;
    logic        w_full;
    logic        w_empty;
    logic [AW:0] w_count;
    logic [7:0]  w_head;
    logic        w_fsm_quiet;
    logic [15:0] w_status;
    logic [15:0] w_rdata;

    assign w_cfg_wr   = iEnable && iWrite && (iAddr == 2'd0);
    assign w_flush    = w_cfg_wr && iData[9];
    assign w_cpu_push = iEnable && iWrite && (iAddr == 2'd1);
    assign w_stat_rd  = iEnable && !iWrite && (iAddr == 2'd0);

    // A flush racing the IDLE->POLL step can leave POLL with nothing to pop.
    assign w_pop = (r_state == ST_POLL) && !iUData[CTRL_SEND] && !w_empty;

    eprisc_sync_fifo #(.DEPTH(DEPTH), .AW(AW)) u_fifo (
        .iClk   (iClk),
        .iRst   (iRst),
        .iPush  (w_cpu_push),
        .iData  (iData[7:0]),
        .iPop   (w_pop),
        .iFlush (w_flush),
        .oData  (w_head),
        .oFull  (w_full),
        .oEmpty (w_empty),
        .oCount (w_count)
    );

    always_ff @(posedge iClk or negedge iRst) begin
        if (!iRst) begin
            r_state     <= ST_IDLE;
            r_cfg       <= '0;
            r_irq_en    <= 1'b0;
            r_overflow  <= 1'b0;
            r_rx_mirror <= '0;
            r_tx_byte   <= '0;
        end else begin
            r_state <= w_next;
            if (w_cfg_wr) begin
                r_cfg    <= iData[6:0];
                r_irq_en <= iData[8];
            end
            if (w_cpu_push && w_full && !w_flush) r_overflow <= 1'b1;
            else if (w_stat_rd)                   r_overflow <= 1'b0;
            if (r_state == ST_RXRD) r_rx_mirror <= iUData;
            if (w_pop)              r_tx_byte   <= w_head;
        end
    end

    always_comb begin
        w_next   = r_state;
        oUAddr   = 2'd0;
        oUData   = 16'h0000;
        oUWrite  = 1'b0;
        oUEnable = 1'b0;
        case (r_state)
            ST_IDLE:  w_next = w_empty ? ST_RXRD : ST_POLL;
            ST_RXRD: begin
                oUEnable = 1'b1;
                oUAddr   = UART_RXD;
                w_next   = ST_IDLE;
            end
            ST_POLL: begin
                oUEnable = 1'b1;
                oUAddr   = UART_CTRL;
                w_next   = w_pop ? ST_WDATA : ST_IDLE;
            end
            ST_WDATA: begin
                oUEnable = 1'b1;
                oUWrite  = 1'b1;
                oUAddr   = UART_DATA;
                oUData   = {8'h00, r_tx_byte};
                w_next   = ST_WCTRL;
            end
            ST_WCTRL: begin
                oUEnable = 1'b1;
                oUWrite  = 1'b1;
                oUAddr   = UART_CTRL;
                oUData   = {8'h00, 1'b1, r_cfg};
                w_next   = ST_GAP;
            end
            ST_GAP:   w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    assign w_fsm_quiet = (r_state == ST_IDLE) || (r_state == ST_RXRD);
    assign oInt        = r_irq_en && w_empty && w_fsm_quiet;

    always_comb begin
        w_status                = 16'h0000;
        w_status[AW:0]          = w_count;
        w_status[STAT_EMPTY]    = w_empty;
        w_status[STAT_FULL]     = w_full;
        w_status[STAT_OVERFLOW] = r_overflow;
        w_status[STAT_BUSY]     = !w_fsm_quiet;
    end

    always_comb begin
        w_rdata = 16'h0000;
        case (iAddr)
            2'd0:    w_rdata = w_status;
            2'd2:    w_rdata = r_rx_mirror;
            2'd3:    w_rdata = 16'(DEPTH);
            default: w_rdata = 16'h0000;
        endcase
    end

    assign oData = iEnable ? w_rdata : 16'bz;

endmodule

// File: tb/tb_eprisc_uart_txq.sv
// Directed bench for eprisc_uart_txq with a behavioural UART register model.
module tb_eprisc_uart_txq;

    logic        iClk = 1'b0;
    logic        iRst = 1'b0;
    logic [1:0]  iAddr = 2'd0;
    logic [15:0] iData = 16'h0;
    logic [15:0] oData;
    logic        iWrite = 1'b0;
    logic        iEnable = 1'b0;
    logic        oInt;
    logic [1:0]  oUAddr;
    logic [15:0] oUData;
    logic [15:0] iUData;
    logic        oUWrite;
    logic        oUEnable;

    int n_vec = 0;
    int n_err = 0;

    // UART model state
    int          busy_cnt = 0;
    int          busy_len = 200;
    logic        force_busy = 1'b0;
    logic [15:0] rx_val = 16'h0000;
    int          viol = 0;
    int          cyc = 0;
    int          log_n = 0;
    logic [1:0]  log_addr [256];
    logic [15:0] log_data [256];
    int          log_cyc  [256];

    eprisc_uart_txq #(.DEPTH(16), .AW(4)) dut (
        .iClk     (iClk),
        .iRst     (iRst),
        .iAddr    (iAddr),
        .iData    (iData),
        .oData    (oData),
        .iWrite   (iWrite),
        .iEnable  (iEnable),
        .oInt     (oInt),
        .oUAddr   (oUAddr),
        .oUData   (oUData),
        .iUData   (iUData),
        .oUWrite  (oUWrite),
        .oUEnable (oUEnable)
    );

    always #5 iClk = ~iClk;

    assign iUData = (oUAddr == 2'd0) ? {8'h00, (busy_cnt != 0) || force_busy, 7'h00} :
                    (oUAddr == 2'd2) ? rx_val : 16'h0000;

    always @(posedge iClk) begin
        cyc <= cyc + 1;
        if (oUWrite && oUEnable) begin
            log_addr[log_n[7:0]] <= oUAddr;
            log_data[log_n[7:0]] <= oUData;
            log_cyc[log_n[7:0]]  <= cyc;
            log_n <= log_n + 1;
            if (busy_cnt != 0 || force_busy) viol <= viol + 1;
        end
        if (oUWrite && oUEnable && oUAddr == 2'd0 && oUData[7]) busy_cnt <= busy_len;
        else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
    end

    task automatic cpu_write(input logic [1:0] a, input logic [15:0] d);
        @(negedge iClk);
        iAddr = a; iData = d; iWrite = 1'b1; iEnable = 1'b1;
        @(negedge iClk);
        iWrite = 1'b0; iEnable = 1'b0;
    endtask

    task automatic cpu_read(input logic [1:0] a, output logic [15:0] d);
        @(negedge iClk);
        iAddr = a; iWrite = 1'b0; iEnable = 1'b1;
        #1 d = oData;
        @(negedge iClk);
        iEnable = 1'b0;
    endtask

    task automatic wait_uart_idle();
        for (int i = 0; i < 400 && busy_cnt != 0; i++) @(negedge iClk);
    endtask

    task automatic test_reset();
        logic [15:0] d;
        iRst = 1'b0;
        repeat (3) @(negedge iClk);
        #1;
        n_vec++;
        if ({oInt, oUWrite, oUEnable, oUAddr, oUData} !== 21'h0) begin
            n_err++;
            $display("FAIL reset_outputs: got oInt=%b oUWrite=%b oUEnable=%b oUAddr=%h oUData=%h, want all 0",
                     oInt, oUWrite, oUEnable, oUAddr, oUData);
        end
        @(negedge iClk);
        iRst = 1'b1;
        repeat (2) @(negedge iClk);
        cpu_read(2'd0, d);
        n_vec++;
        if (d !== 16'h0100) begin
            n_err++; $display("FAIL reset_status: got %h want 0100", d);
        end
        cpu_read(2'd3, d);
        n_vec++;
        if (d !== 16'h0010) begin
            n_err++; $display("FAIL depth_reg: got %h want 0010", d);
        end
        #1;
        n_vec++;
        if (oInt !== 1'b0) begin
            n_err++; $display("FAIL reset_int: got %b want 0", oInt);
        end
    endtask

    task automatic test_single();
        logic [15:0] d;
        int base, push_cyc, lat;
        cpu_write(2'd0, 16'h0003);
        base = log_n;
        cpu_write(2'd1, 16'h0041);
        push_cyc = cyc - 1;
        for (int i = 0; i < 30 && log_n < base + 2; i++) @(negedge iClk);
        n_vec++;
        if (log_n < base + 2) begin
            n_err++; $display("FAIL single_timeout: got %0d writes want 2", log_n - base);
        end else begin
            n_vec++;
            if (log_addr[base] !== 2'd1 || log_data[base] !== 16'h0041) begin
                n_err++; $display("FAIL single_data: got addr %0d data %h want addr 1 data 0041",
                                  log_addr[base], log_data[base]);
            end
            n_vec++;
            if (log_addr[base+1] !== 2'd0 || log_data[base+1] !== 16'h0083 ||
                log_cyc[base+1] != log_cyc[base] + 1) begin
                n_err++; $display("FAIL single_ctrl: got addr %0d data %h dt %0d want addr 0 data 0083 dt 1",
                                  log_addr[base+1], log_data[base+1], log_cyc[base+1] - log_cyc[base]);
            end
            lat = log_cyc[base] - push_cyc;
            n_vec++;
            if (lat < 3 || lat > 4) begin
                n_err++; $display("FAIL single_latency: got %0d edges want 3..4", lat);
            end
        end
        repeat (3) @(negedge iClk);
        cpu_read(2'd0, d);
        n_vec++;
        if (d !== 16'h0100) begin
            n_err++; $display("FAIL single_drained: got %h want 0100", d);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_b [3];
        int base, v0;
        exp_b[0] = 8'h11; exp_b[1] = 8'h22; exp_b[2] = 8'h33;
        base = log_n;
        v0 = viol;
        for (int i = 0; i < 3; i++) cpu_write(2'd1, {8'h00, exp_b[i]});
        for (int i = 0; i < 1500 && log_n < base + 6; i++) @(negedge iClk);
        n_vec++;
        if (log_n < base + 6) begin
            n_err++; $display("FAIL b2b_timeout: got %0d writes want 6", log_n - base);
        end else begin
            for (int i = 0; i < 3; i++) begin
                n_vec++;
                if (log_addr[base+2*i] !== 2'd1 || log_data[base+2*i] !== {8'h00, exp_b[i]} ||
                    log_data[base+2*i+1] !== 16'h0083) begin
                    n_err++; $display("FAIL b2b_order%0d: got data %h ctrl %h want %h ctrl 0083",
                                      i, log_data[base+2*i], log_data[base+2*i+1], {8'h00, exp_b[i]});
                end
            end
            n_vec++;
            if (log_cyc[base+2] - log_cyc[base+1] <= 200 || log_cyc[base+4] - log_cyc[base+3] <= 200) begin
                n_err++; $display("FAIL b2b_spacing: got gaps %0d %0d want >200",
                                  log_cyc[base+2] - log_cyc[base+1], log_cyc[base+4] - log_cyc[base+3]);
            end
        end
        n_vec++;
        if (viol != v0) begin
            n_err++; $display("FAIL b2b_busy_write: got %0d writes while busy want 0", viol - v0);
        end
    endtask

    task automatic test_overflow();
        logic [15:0] d;
        force_busy = 1'b1;
        for (int i = 0; i < 17; i++) cpu_write(2'd1, 16'h0060 + 16'(i));
        cpu_read(2'd0, d);
        n_vec++;
        if ((d & 16'hF7FF) !== 16'h0610) begin
            n_err++; $display("FAIL ovf_status: got %h want 0610 (bit11 ignored)", d);
        end
        cpu_read(2'd0, d);
        n_vec++;
        if ((d & 16'hF7FF) !== 16'h0210) begin
            n_err++; $display("FAIL ovf_clear: got %h want 0210 (bit11 ignored)", d);
        end
        cpu_write(2'd0, 16'h0203);
        cpu_read(2'd0, d);
        n_vec++;
        if ((d & 16'hF7FF) !== 16'h0100) begin
            n_err++; $display("FAIL flush: got %h want 0100 (bit11 ignored)", d);
        end
        force_busy = 1'b0;
    endtask

    task automatic test_irq();
        int found;
        wait_uart_idle();
        cpu_write(2'd0, 16'h0103);
        repeat (2) @(negedge iClk);
        #1;
        n_vec++;
        if (oInt !== 1'b1) begin
            n_err++; $display("FAIL irq_empty: got %b want 1", oInt);
        end
        cpu_write(2'd1, 16'h0077);
        #1;
        n_vec++;
        if (oInt !== 1'b0) begin
            n_err++; $display("FAIL irq_push: got %b want 0", oInt);
        end
        found = 0;
        for (int i = 0; i < 50 && !found; i++) begin
            @(negedge iClk); #1;
            if (oInt === 1'b1) found = 1;
        end
        n_vec++;
        if (found != 1) begin
            n_err++; $display("FAIL irq_drained: got oInt %b want 1 after drain", oInt);
        end
        cpu_write(2'd0, 16'h0003);
    endtask

    task automatic test_rx_mirror();
        logic [15:0] d;
        rx_val = 16'h005A;
        repeat (2) @(negedge iClk);
        cpu_read(2'd2, d);
        n_vec++;
        if (d !== 16'h005A) begin
            n_err++; $display("FAIL rx_mirror: got %h want 005A", d);
        end
        rx_val = 16'h00A5;
        repeat (2) @(negedge iClk);
        cpu_read(2'd2, d);
        n_vec++;
        if (d !== 16'h00A5) begin
            n_err++; $display("FAIL rx_mirror2: got %h want 00A5", d);
        end
    endtask

    task automatic test_reset_mid();
        logic [15:0] d;
        int found;
        wait_uart_idle();
        cpu_write(2'd1, 16'h0099);
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (oUWrite === 1'b1 && oUAddr === 2'd1) found = 1;
            else begin @(negedge iClk); #1; end
        end
        n_vec++;
        if (found != 1) begin
            n_err++; $display("FAIL rstmid_wdata: got no WDATA cycle want one within 20");
        end
        iRst = 1'b0;
        #1;
        n_vec++;
        if ({oUWrite, oUEnable, oUAddr, oUData} !== 20'h0) begin
            n_err++; $display("FAIL rstmid_outputs: got oUWrite=%b oUEnable=%b oUAddr=%h oUData=%h want all 0",
                              oUWrite, oUEnable, oUAddr, oUData);
        end
        @(negedge iClk);
        iRst = 1'b1;
        repeat (2) @(negedge iClk);
        cpu_read(2'd0, d);
        n_vec++;
        if (d !== 16'h0100) begin
            n_err++; $display("FAIL rstmid_status: got %h want 0100", d);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_overflow();
        test_irq();
        test_rx_mirror();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
